// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU, with one registered response slot per requester.
// Build option: define ALU_ARB_FAIR_EN for a round-robin tie-break; otherwise requester 0 wins every tie.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,

  output logic [WIDTH-1:0] alu_in_a,
  output logic [WIDTH-1:0] alu_in_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       slot_free;
  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic             pick1;

  logic [1:0]       rsp_valid_reg;
  logic [1:0]       rsp_zero_reg;
  logic [WIDTH-1:0] rsp_result_reg [2];

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A slot is free when empty or being drained this cycle, so a drain and a new accept can share a cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign slot_free[gi] = ~rsp_valid_reg[gi] | rsp_ready[gi];
      assign eligible[gi]  = req_valid[gi] & slot_free[gi];
    end
  endgenerate

`ifdef ALU_ARB_FAIR_EN
  logic prio_reg;

  assign pick1 = eligible[1] & (~eligible[0] | prio_reg);

  // Only a contended grant moves the pointer, and it moves to the loser.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_reg <= 1'b0;
    end else if (&eligible) begin
      prio_reg <= ~pick1;
    end
  end
`else
  assign pick1 = eligible[1] & ~eligible[0];
`endif

  assign grant[0] = ~reset & eligible[0] & ~pick1;
  assign grant[1] = ~reset & pick1;

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    alu_in_a    = '0;
    alu_in_b    = '0;
    alu_control = 4'b0000;
    if (grant[0]) begin
      alu_in_a    = req0_a;
      alu_in_b    = req0_b;
      alu_control = req0_op;
    end else if (grant[1]) begin
      alu_in_a    = req1_a;
      alu_in_b    = req1_b;
      alu_control = req1_op;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        rsp_valid_reg[i]  <= 1'b0;
        rsp_result_reg[i] <= '0;
        rsp_zero_reg[i]   <= 1'b0;
      end else if (grant[i]) begin
        rsp_valid_reg[i]  <= 1'b1;
        rsp_result_reg[i] <= alu_result;
        rsp_zero_reg[i]   <= alu_zero;
      end else if (rsp_ready[i]) begin
        rsp_valid_reg[i]  <= 1'b0;
      end
    end
  end

  assign rsp0_valid  = rsp_valid_reg[0];
  assign rsp0_result = rsp_result_reg[0];
  assign rsp0_zero   = rsp_zero_reg[0];
  assign rsp1_valid  = rsp_valid_reg[1];
  assign rsp1_result = rsp_result_reg[1];
  assign rsp1_zero   = rsp_zero_reg[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and per-requester expected-result queues.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0]  req0_op = 0, req1_op = 0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [31:0] alu_in_a, alu_in_b, alu_result;
  logic [3:0]  alu_control;
  logic        alu_zero;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  logic exp_g1;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0100: return a ^ b;
      4'b0110: return a - b;
      4'b0111: return {31'b0, $signed(a) < $signed(b)};
      default: return 32'h0;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t e;
    e.result = alu_f(a, b, op);
    e.zero   = (e.result == 32'h0);
    return e;
  endfunction

  assign alu_result = alu_f(alu_in_a, alu_in_b, alu_control);
  assign alu_zero   = (alu_result == 32'h0);

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare a presented response against the queue head, pop on drain, push on accept.
  task automatic monitor();
    chk("one_grant", {31'b0, req0_ready & req1_ready}, 32'h0);
    if (rsp0_valid) begin
      if (q0.size() == 0) chk("rsp0_unexpected", 32'h1, 32'h0);
      else begin
        chk("rsp0_result", rsp0_result, q0[0].result);
        chk("rsp0_zero", {31'b0, rsp0_zero}, {31'b0, q0[0].zero});
        if (rsp0_ready) void'(q0.pop_front());
      end
    end
    if (rsp1_valid) begin
      if (q1.size() == 0) chk("rsp1_unexpected", 32'h1, 32'h0);
      else begin
        chk("rsp1_result", rsp1_result, q1[0].result);
        chk("rsp1_zero", {31'b0, rsp1_zero}, {31'b0, q1[0].zero});
        if (rsp1_ready) void'(q1.pop_front());
      end
    end
    if (req0_valid && req0_ready) q0.push_back(model(req0_a, req0_b, req0_op));
    if (req1_valid && req1_ready) q1.push_back(model(req1_a, req1_b, req1_op));
    $display("cycle t=%0t g0=%0b g1=%0b rsp0_v=%0b rsp1_v=%0b alu_ctl=%0h", $time,
             req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_control);
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a pending request: grants and ALU drive must be forced off.
    req0_valid = 1; req0_a = 32'h55; req0_b = 32'h1; req0_op = 4'b0010;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req0_ready", {31'b0, req0_ready}, 32'h0);
    chk("rst_alu_control", {28'b0, alu_control}, 32'h0);
    chk("rst_alu_in_a", alu_in_a, 32'h0);
    chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'h0);
    chk("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'h0);
    chk("rst_rsp0_result", rsp0_result, 32'h0);
    chk("rst_rsp1_zero", {31'b0, rsp1_zero}, 32'h0);
    reset = 0;
    req0_valid = 0;

    // Single request: 5 + 3.
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 4'b0010;
    #1;
    chk("single_ready", {31'b0, req0_ready}, 32'h1);
    chk("single_alu_a", alu_in_a, 32'd5);
    chk("single_alu_ctl", {28'b0, alu_control}, 32'h2);
    cycle();
    req0_valid = 0;
    #1;
    chk("single_rsp_valid", {31'b0, rsp0_valid}, 32'h1);
    chk("single_result", rsp0_result, 32'd8);
    chk("single_zero", {31'b0, rsp0_zero}, 32'h0);
    cycle();
    chk("single_rsp_clear", {31'b0, rsp0_valid}, 32'h0);

    // Zero flag on requester 1: 7 ^ 7.
    req1_valid = 1; req1_a = 7; req1_b = 7; req1_op = 4'b0100;
    cycle();
    req1_valid = 0;
    #1;
    chk("zero_rsp_valid", {31'b0, rsp1_valid}, 32'h1);
    chk("zero_result", rsp1_result, 32'h0);
    chk("zero_flag", {31'b0, rsp1_zero}, 32'h1);
    cycle();

    // Contention: both requesters valid every cycle, both consumers ready.
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1; req0_a = i + 1; req0_b = 2;      req0_op = 4'b0010;
      req1_valid = 1; req1_a = 100;   req1_b = i * 3;  req1_op = 4'b0110;
      #1;
`ifdef ALU_ARB_FAIR_EN
      exp_g1 = (i % 2 == 1);
`else
      exp_g1 = 1'b0;
`endif
      chk("contend_g1", {31'b0, req1_ready}, {31'b0, exp_g1});
      chk("contend_g0", {31'b0, req0_ready}, {31'b0, ~exp_g1});
      cycle();
    end
    req0_valid = 0; req1_valid = 0;
    cycle();

    // Idle with consumers stalled: ALU inputs zero, no response appears.
    rsp0_ready = 0; rsp1_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("idle_alu_ctl", {28'b0, alu_control}, 32'h0);
      chk("idle_alu_a", alu_in_a, 32'h0);
      chk("idle_alu_b", alu_in_b, 32'h0);
      chk("idle_rsp0_valid", {31'b0, rsp0_valid}, 32'h0);
      chk("idle_rsp1_valid", {31'b0, rsp1_valid}, 32'h0);
      cycle();
    end

    // Backpressure on requester 0, then drain and accept in the same cycle.
    rsp1_ready = 1;
    req0_valid = 1; req0_a = 10; req0_b = 4; req0_op = 4'b0110;
    #1;
    chk("bp_first_ready", {31'b0, req0_ready}, 32'h1);
    cycle();
    req0_a = 20; req0_b = 1; req0_op = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bp_stall_ready", {31'b0, req0_ready}, 32'h0);
      chk("bp_held_result", rsp0_result, 32'd6);
      cycle();
    end
    rsp0_ready = 1;
    #1;
    chk("bp_drain_ready", {31'b0, req0_ready}, 32'h1);
    cycle();
    chk("bp_valid_kept", {31'b0, rsp0_valid}, 32'h1);
    chk("bp_new_result", rsp0_result, 32'd21);
    req0_valid = 0;
    cycle();

    // Fill both slots, then reset mid-stream.
    rsp0_ready = 0; rsp1_ready = 0;
    req0_valid = 1; req0_a = 3; req0_b = 3; req0_op = 4'b0001;
    req1_valid = 1; req1_a = 8; req1_b = 2; req1_op = 4'b0000;
    repeat (2) cycle();
    chk("pre_rst_rsp0_valid", {31'b0, rsp0_valid}, 32'h1);
    chk("pre_rst_rsp1_valid", {31'b0, rsp1_valid}, 32'h1);
    reset = 1;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    chk("midrst_req0_ready", {31'b0, req0_ready}, 32'h0);
    chk("midrst_req1_ready", {31'b0, req1_ready}, 32'h0);
    chk("midrst_alu_ctl", {28'b0, alu_control}, 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_rsp0_valid", {31'b0, rsp0_valid}, 32'h0);
    chk("midrst_rsp1_valid", {31'b0, rsp1_valid}, 32'h0);
    chk("midrst_rsp0_result", rsp0_result, 32'h0);
    chk("midrst_rsp1_result", rsp1_result, 32'h0);
    q0.delete();
    q1.delete();
    reset = 0;
    #1;
    chk("post_rst_g0", {31'b0, req0_ready}, 32'h1);
    chk("post_rst_g1", {31'b0, req1_ready}, 32'h0);
    cycle();
    req0_valid = 0; req1_valid = 0;
    repeat (2) cycle();
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters: requester 0 is the execute stage and requester 1 is the branch/address unit. Each requester has a valid/ready request channel and a registered valid/ready response channel. Per cycle, at most one request is issued to the ALU. The result and zero flag are captured into the granted requester's response register, so latency is one cycle.

## Interface
- WIDTH, 32, operand/result width; must match the ALU.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when high with valid.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_op / req1_op  in  4  ALU control code, passed through unmodified.
- rsp0_valid / rsp1_valid  out  1  registered result available.
- rsp0_ready / rsp1_ready  in  1  consumer takes result this cycle.
- rsp0_result / rsp1_result  out  WIDTH  registered ALU result.
- rsp0_zero / rsp1_zero  out  1  registered ALU zero flag.
- alu_in_a, alu_in_b  out  WIDTH  operands to the ALU.
- alu_control  out  4  op code to the ALU.
- alu_result  in  WIDTH  ALU result, combinational.
- alu_zero  in  1  ALU zero flag, combinational.

## Operation
- slot_free_i = ~rsp_i_valid | rsp_i_ready.
- eligible_i = req_i_valid & slot_free_i.
- Grant, at most one per cycle:
  - If only one requester is eligible, it wins.
  - If both are eligible, the requester selected by priority pointer `prio` wins.
- req_i_ready = grant_i. Ready is combinational from valid and rsp_ready. It never depends on the other requester's ready.
- ALU drive:
  - On a grant, alu_in_a, alu_in_b and alu_control carry the granted requester's a, b and op.
  - With no grant, all three are 0 (ALU op 0000, AND of zeros).
- Response register i on rising edge:
  - If grant_i: capture alu_result/alu_zero and set rsp_i_valid=1.
  - Else if rsp_i_ready: clear rsp_i_valid.
  - Else hold.
  - result/zero change only on grant_i.
- Simultaneous drain and accept (rsp_i_valid & rsp_i_ready & grant_i): new result overwrites and rsp_i_valid stays 1. No bubble, so throughput is 1 op/cycle per requester when uncontended.
- No reordering: each requester's responses return in request order. There is at most one outstanding result per requester.
- Op codes are not checked. An undefined op yields whatever the ALU produces.
- Reset values:
  - rsp0_valid = rsp1_valid = 0.
  - rsp*_result = 0.
  - rsp*_zero = 0.
  - prio = 0 (requester 0 favoured).
- Reset mid-operation discards any held results and returns prio to 0.
- Combinational outputs follow the inputs during reset, with grants forced to 0: req*_ready = 0 and alu_* = 0 while reset is high.

## Timing
- Accept in cycle N: rsp_i_valid is high, with result, from cycle N+1.
- A stalled response (rsp_i_valid=1, rsp_i_ready=0) holds req_i_ready=0 until the drain cycle. In the drain cycle a new request may be accepted in the same cycle.
- The ALU path is combinational inside the accept cycle: req mux → ALU → response register. This is the critical path.
- prio updates on rising edge only when a contended grant occurs (both eligible). It then points to the requester that lost. An uncontended grant leaves prio unchanged.

## Configuration
- ALU_ARB_FAIR_EN defined: round-robin priority pointer as described above.
- ALU_ARB_FAIR_EN undefined:
  - Fixed priority: requester 0 always wins when both are eligible.
  - prio register is removed.
  - Requester 1 may starve under continuous requester-0 traffic. This is acceptable because requester 1 is not latency critical in that build.

## Test plan
- Single request: req0 a=5, b=3, op=0010 in cycle N with rsp0_ready=1 → req0_ready=1 in N; rsp0_valid=1, rsp0_result=8, rsp0_zero=0 in N+1; rsp0_valid=0 in N+2.
- Zero flag: req1 a=7, b=7, op=0100 → rsp1_result=0, rsp1_zero=1 one cycle later.
- Contention (FAIR defined): both valid every cycle, both rsp_ready=1 → grants alternate 0,1,0,1 starting with 0 after reset. Undefined: req0 granted every cycle and req1_ready stays 0.
- Backpressure: rsp0_ready=0 after first result → req0_ready=0 and result held stable. Raise rsp0_ready with req0 still valid → drain and new accept in the same cycle; rsp0_valid stays 1 with the new value.
- Idle: no valid for 4 cycles → alu_control=0000, alu_in_a=alu_in_b=0, no rsp_valid change.
- Reset mid-stream: assert reset while rsp0_valid=1 and rsp1_valid=1 → next edge both rsp_valid=0, results 0. First contended grant after release goes to requester 0.
